stream_return_router: RTL

- Return-path companion to the forward crossbar data net. It takes M_DATA_COUNT response streams from the slave side and routes each packet back to the S_DATA_COUNT master-side ports.
- Routing uses the source id that the forward net attached (m_id). The block tags each delivered packet with the slave port it came from.
- Arbitration is per output port, round-robin, and packet-locked: a grant is held until the last beat.
- Each output has a registered (pipelined) stage.

---
 rtl/stream_xbar_pkg.sv | 16 +
 rtl/rr_packet_arbiter.sv | 76 +++++++
 rtl/stream_return_router.sv | 134 +++++++++++++
 3 files changed

// File: rtl/stream_xbar_pkg.sv
// Shared types and helpers for the stream crossbar return path.
//   arb_state_t : per-output arbiter state (IDLE, BUSY)
//   safe_clog2  : index width that never collapses to zero bits
package stream_xbar_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Width of an index into n items, at least one bit.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_packet_arbiter.sv
// Packet-locked round-robin arbiter for one output port.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req          : one request bit per input
//   accept       : a beat of the granted input is taken this cycle
//   last         : last flag of the granted input's current beat
//   grant        : index of the granted input (meaningful while busy)
//   busy         : a packet is currently locked onto this output
module rr_packet_arbiter
    import stream_xbar_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = safe_clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req,
    input  logic          accept,
    input  logic          last,
    output logic [IW-1:0] grant,
    output logic          busy
);

    arb_state_t    state_r;
    logic [IW-1:0] grant_r;
    logic [IW-1:0] ptr_r;
    logic          found_s;
    logic [IW-1:0] pick_s;

    // Round-robin search: first requester strictly after the pointer, wrapping.
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = int'(ptr_r) + k;
            idx = (idx >= N) ? (idx - N) : idx;
            pick_s  = (!found_s && req[idx]) ? IW'(idx) : pick_s;
            found_s = found_s || req[idx];
        end
    end

    // Arbiter FSM: grant in IDLE, hold the grant until the last beat is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            grant_r <= '0;
            ptr_r   <= IW'(N - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        grant_r <= pick_s;
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (accept && last) begin
                        ptr_r   <= grant_r;
                        state_r <= IDLE;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign grant = grant_r;
    assign busy  = (state_r == BUSY);

endmodule

// File: rtl/stream_return_router.sv
// Return-path router: steers response packets from M slave-side inputs to
// S master-side outputs by their routing id, tagging each packet with the
// input it came from. One packet-locked round-robin arbiter and one output
// register per output.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   r_data_i/r_id_i       : per-input payload and target output (flattened)
//   r_last_i/r_valid_i    : per-input end-of-packet and valid
//   r_ready_o             : per-input beat accept
//   q_data_o/q_dest_o     : per-output payload and source tag (flattened)
//   q_last_o/q_valid_o    : per-output end-of-packet and valid
//   q_ready_i             : per-output ready
module stream_return_router
    import stream_xbar_pkg::*;
#(
    parameter  int T_DATA_WIDTH = 8,
    parameter  int S_DATA_COUNT = 2,
    parameter  int M_DATA_COUNT = 3,
    localparam int T_ID___WIDTH = safe_clog2(S_DATA_COUNT),
    localparam int T_DEST_WIDTH = safe_clog2(M_DATA_COUNT)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [M_DATA_COUNT*T_DATA_WIDTH-1:0] r_data_i,
    input  logic [M_DATA_COUNT*T_ID___WIDTH-1:0] r_id_i,
    input  logic [M_DATA_COUNT-1:0]              r_last_i,
    input  logic [M_DATA_COUNT-1:0]              r_valid_i,
    output logic [M_DATA_COUNT-1:0]              r_ready_o,
    output logic [S_DATA_COUNT*T_DATA_WIDTH-1:0] q_data_o,
    output logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] q_dest_o,
    output logic [S_DATA_COUNT-1:0]              q_last_o,
    output logic [S_DATA_COUNT-1:0]              q_valid_o,
    input  logic [S_DATA_COUNT-1:0]              q_ready_i
);

    logic [M_DATA_COUNT-1:0] req_s        [S_DATA_COUNT];
    logic [T_DEST_WIDTH-1:0] grant_s      [S_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] busy_s;
    logic [S_DATA_COUNT-1:0] stage_ready_s;
    logic [S_DATA_COUNT-1:0] accept_s;
    logic [T_DATA_WIDTH-1:0] sel_data_s   [S_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] sel_last_s;
    logic [S_DATA_COUNT-1:0] sel_valid_s;
    logic [M_DATA_COUNT-1:0] in_range_s;
    logic [M_DATA_COUNT-1:0] ready_hit_s;
    logic [M_DATA_COUNT-1:0] r_ready_s;

    logic [T_DATA_WIDTH-1:0] q_data_r     [S_DATA_COUNT];
    logic [T_DEST_WIDTH-1:0] q_dest_r     [S_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] q_last_r;
    logic [S_DATA_COUNT-1:0] q_valid_r;

    // Request decode per output and granted-input beat selection.
    always_comb begin
        for (int j = 0; j < S_DATA_COUNT; j++) begin
            stage_ready_s[j] = !q_valid_r[j] || q_ready_i[j];
            sel_data_s[j]    = '0;
            sel_last_s[j]    = 1'b0;
            sel_valid_s[j]   = 1'b0;
            for (int i = 0; i < M_DATA_COUNT; i++) begin
                req_s[j][i]    = r_valid_i[i] &&
                                 (r_id_i[i*T_ID___WIDTH +: T_ID___WIDTH] == T_ID___WIDTH'(j));
                sel_data_s[j]  = (grant_s[j] == T_DEST_WIDTH'(i)) ?
                                 r_data_i[i*T_DATA_WIDTH +: T_DATA_WIDTH] : sel_data_s[j];
                sel_last_s[j]  = (grant_s[j] == T_DEST_WIDTH'(i)) ? r_last_i[i]  : sel_last_s[j];
                sel_valid_s[j] = (grant_s[j] == T_DEST_WIDTH'(i)) ? r_valid_i[i] : sel_valid_s[j];
            end
            accept_s[j] = busy_s[j] && stage_ready_s[j] && sel_valid_s[j];
        end
    end

    // Input ready: the output named by the id must be locked onto this input
    // with room in its register; ids with no matching output are drained.
    always_comb begin
        for (int i = 0; i < M_DATA_COUNT; i++) begin
            in_range_s[i]  = int'(r_id_i[i*T_ID___WIDTH +: T_ID___WIDTH]) < S_DATA_COUNT;
            ready_hit_s[i] = 1'b0;
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                ready_hit_s[i] = ready_hit_s[i] ||
                                 ((r_id_i[i*T_ID___WIDTH +: T_ID___WIDTH] == T_ID___WIDTH'(j)) &&
                                  busy_s[j] && (grant_s[j] == T_DEST_WIDTH'(i)) &&
                                  stage_ready_s[j]);
            end
            r_ready_s[i] = !rst_i && (!in_range_s[i] || ready_hit_s[i]);
        end
    end

    for (genvar j = 0; j < S_DATA_COUNT; j++) begin : g_out
        rr_packet_arbiter #(
            .N (M_DATA_COUNT)
        ) u_arb (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .req    (req_s[j]),
            .accept (accept_s[j]),
            .last   (sel_last_s[j]),
            .grant  (grant_s[j]),
            .busy   (busy_s[j])
        );

        assign q_data_o[j*T_DATA_WIDTH +: T_DATA_WIDTH] = q_data_r[j];
        assign q_dest_o[j*T_DEST_WIDTH +: T_DEST_WIDTH] = q_dest_r[j];
    end

    // Output register per port: loads whenever the arbiter is locked and the
    // slot is free; valid follows the granted input's valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_valid_r <= '0;
            q_last_r  <= '0;
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                q_data_r[j] <= '0;
                q_dest_r[j] <= '0;
            end
        end else begin
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                if (busy_s[j] && stage_ready_s[j]) begin
                    q_valid_r[j] <= sel_valid_s[j];
                    q_last_r[j]  <= sel_last_s[j];
                    q_data_r[j]  <= sel_data_s[j];
                    q_dest_r[j]  <= grant_s[j];
                end else if (q_ready_i[j]) begin
                    q_valid_r[j] <= 1'b0;
                end else begin
                    q_valid_r[j] <= q_valid_r[j];
                end
            end
        end
    end

    assign r_ready_o = r_ready_s;
    assign q_last_o  = q_last_r;
    assign q_valid_o = q_valid_r;

endmodule
